riscv_fetch_queue: RTL

Instruction-fetch front end for the 5-stage RISC-V pipeline. It issues in-order word fetches to a variable-latency instruction memory and buffers returned instructions with their PCs in a small queue. It presents one instruction per cycle to the IF/ID register, which holds it under a decode-side stall. A redirect from the branch-resolving stage flushes the queue and drops any responses still in flight.

---
 rtl/riscv_fetch_queue.sv | 116 +++++++++++
 1 files changed

// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: in-order instruction fetch front end.
// Issues word fetches to a variable-latency instruction memory under a credit
// scheme that reserves a queue slot for every request in flight, buffers the
// returned words with their PCs, and presents the oldest one to IF/ID.
// A redirect empties the queue and marks every request still in flight for
// discard, so stale words never reach decode.
module riscv_fetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter logic [31:0] NOP             = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_ir,
  output logic [63:0] ifid_pc,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [63:0]   fetch_pc;
  logic [63:0]   resp_pc;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop;

  logic [63:0]   pc_q [DEPTH];
  logic [31:0]   ir_q [DEPTH];

  logic          accept;
  logic          rsp;
  logic          push;
  logic          pop;
  logic [OW-1:0] out_next;
  logic [63:0]   redirect_base;

  // Masking keeps every redirect_pc bit in the expression; the low two are
  // forced to zero so fetches stay word aligned.
  assign redirect_base = redirect_pc & ~64'd3;

  // Credit check: a request is only issued if the queue can absorb its answer
  // on top of everything already buffered or in flight.
  assign imem_req = !reset && !redirect
                    && ((int'(count) + int'(outstanding)) < DEPTH)
                    && (int'(outstanding) < MAX_OUTSTANDING);
  assign imem_addr = fetch_pc;

  assign accept   = imem_req && imem_ready;
  // Responses with nothing in flight are spurious and ignored entirely.
  assign rsp      = imem_rvalid && (outstanding != '0);
  assign push     = rsp && (drop == '0) && !redirect;
  assign pop      = ifid_valid && !stall;
  assign out_next = outstanding + OW'(accept) - OW'(rsp);

  // Head of queue drives IF/ID directly; nothing combinational from imem_rdata.
  assign ifid_valid = (count != '0);
  assign ifid_ir    = ifid_valid ? ir_q[head] : NOP;
  assign ifid_pc    = ifid_valid ? pc_q[head] : 64'h0;

  // Control state: PCs, queue pointers, occupancy, in-flight and discard counts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc    <= redirect_base;
      resp_pc     <= redirect_base;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= out_next;
      drop        <= out_next;
    end else begin
      if (accept)
        fetch_pc <= fetch_pc + 64'd4;
      outstanding <= out_next;
      if (rsp && (drop != '0))
        drop <= drop - OW'(1);
      if (push) begin
        resp_pc <= resp_pc + 64'd4;
        tail    <= tail + AW'(1);
      end
      if (pop)
        head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue payload storage; needs no reset since occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_q[tail] <= resp_pc;
      ir_q[tail] <= imem_rdata;
    end
  end

endmodule
